mips_mc_core: RTL



---
 rtl/mips_mc_pkg.sv | 52 +++++
 rtl/mips_mc_alu.sv | 32 +++
 rtl/mips_mc_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared definitions for the multi-cycle MIPS core.
// Contents:
//   - FSM state encodings, kept as plain 3-bit constants so that legacy
//     debug tooling can decode state_o directly.
//   - Opcode and funct field values.
//   - The ALU operation enum.
//   - Small decode helpers used by the core.
package mips_mc_pkg;

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Opcodes that proceed from ID into EX; anything else retires as a nop.
  function automatic logic op_known(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

  // R-type functs that produce a register write; others retire in EX.
  function automatic logic funct_known(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/mips_mc_alu.sv
// mips_mc_alu: combinational ALU of the multi-cycle core.
// Ports:
//   a, b    : 32-bit operands
//   alu_op  : operation select (alu_op_t)
//   y       : 32-bit result, modulo 2^32
//   zero    : y == 0, used for the beq comparison
module mips_mc_alu
  import mips_mc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] y,
  output logic        zero
);

  // Plain operation select; slt compares the operands as signed values.
  always_comb begin
    y = '0;
    case (alu_op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS core (IF/ID/EX/MEM/WB/HALT FSM).
// Parameters: DMEM_AW (data RAM word address width), RESET_PC, HALT_OPCODE.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   imem_req/imem_addr  : fetch request held with pc until imem_ack
//   imem_ack/imem_rdata : fetch response, sampled while imem_req is high
//   result              : last value written back to the register file
//   halted              : core parked after fetching HALT_OPCODE
//   state_o             : current FSM state for debug
//   retire_valid/pc     : per-instruction retire trace
// Build option: define TRACE_EN to enable the retire trace; without it
// retire_valid and retire_pc are constant 0.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter int          DMEM_AW     = 10,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] result,
  output logic        halted,
  output logic [2:0]  state_o,
  output logic        retire_valid,
  output logic [31:0] retire_pc
);

  logic [2:0]  state;
  logic [31:0] pc, npc, ir, a_reg, b_reg, alu_out, mdr;
  logic [31:0] regs [32];
  logic [31:0] dmem [2**DMEM_AW];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wb_dest;
  logic [15:0] imm;
  logic [31:0] rd_a, rd_b, alu_b, alu_y, wb_value;
  logic        alu_zero;
  alu_op_t     alu_op;
  logic [DMEM_AW-1:0] dmem_idx;
  logic        unused_shamt;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign imm   = ir[15:0];
  assign funct = ir[5:0];
  assign unused_shamt = ^ir[10:6];

  assign rd_a = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rd_b = (rt == 5'd0) ? 32'd0 : regs[rt];

  assign wb_dest  = (op == OP_RTYPE) ? rd : rt;
  assign wb_value = (op == OP_LW) ? mdr : alu_out;
  assign dmem_idx = alu_out[DMEM_AW+1:2];

  // Reset drops the request immediately so a fetch in flight is abandoned.
  assign imem_req  = (state == S_IF) && !rst;
  assign imem_addr = pc;
  assign state_o   = state;

  // ALU control: R-type and beq use register B; immediates feed everything
  // else. beq subtracts so that the zero flag signals equality.
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = sext16(imm);
    if (op == OP_RTYPE) begin
      alu_b = b_reg;
      case (funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (op == OP_BEQ) begin
      alu_b  = b_reg;
      alu_op = ALU_SUB;
    end
  end

  mips_mc_alu u_alu (
    .a      (a_reg),
    .b      (alu_b),
    .alu_op (alu_op),
    .y      (alu_y),
    .zero   (alu_zero)
  );

  // Main sequencer: one state per step, with pc updated in IF (fall
  // through) or in EX (taken beq, j). HALT is absorbing until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IF;
      pc      <= RESET_PC;
      npc     <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      result  <= '0;
      halted  <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            pc    <= pc + 32'd4;
            npc   <= pc + 32'd4;
            state <= S_ID;
          end
        end
        S_ID: begin
          a_reg <= rd_a;
          b_reg <= rd_b;
          if (op == HALT_OPCODE) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (op_known(op)) begin
            state <= S_EX;
          end else begin
            state <= S_IF;
          end
        end
        S_EX: begin
          alu_out <= alu_y;
          case (op)
            OP_RTYPE: state <= funct_known(funct) ? S_WB : S_IF;
            OP_ADDI:  state <= S_WB;
            OP_LW,
            OP_SW:    state <= S_MEM;
            OP_BEQ: begin
              if (alu_zero) pc <= npc + (sext16(imm) << 2);
              state <= S_IF;
            end
            OP_J: begin
              pc    <= {npc[31:28], ir[25:0], 2'b00};
              state <= S_IF;
            end
            default: state <= S_IF;
          endcase
        end
        S_MEM:   state <= (op == OP_LW) ? S_WB : S_IF;
        S_WB: begin
          result <= wb_value;
          state  <= S_IF;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // Register file: cleared by reset, written only in WB; $0 is never stored
  // even though result still reflects the discarded value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (state == S_WB && wb_dest != 5'd0) begin
      regs[wb_dest] <= wb_value;
    end
  end

  // Data RAM is deliberately not reset; the load reads synchronously into
  // MDR in MEM so WB can write it back on the following edge.
  always_ff @(posedge clk) begin
    if (state == S_MEM) begin
      if (op == OP_SW) dmem[dmem_idx] <= b_reg;
      mdr <= dmem[dmem_idx];
    end
  end

`ifdef TRACE_EN
  // Retire marks the last state an instruction occupies before the next
  // fetch; npc still holds the fall-through address, so npc-4 is its pc.
  always_comb begin
    retire_valid = 1'b0;
    case (state)
      S_ID:    retire_valid = (op != HALT_OPCODE) && !op_known(op);
      S_EX:    retire_valid = (op == OP_BEQ) || (op == OP_J) ||
                              ((op == OP_RTYPE) && !funct_known(funct));
      S_MEM:   retire_valid = (op == OP_SW);
      S_WB:    retire_valid = 1'b1;
      default: retire_valid = 1'b0;
    endcase
  end

  assign retire_pc = retire_valid ? (npc - 32'd4) : 32'd0;
`else
  assign retire_valid = 1'b0;
  assign retire_pc    = 32'd0;
`endif

endmodule
